// File: rtl/prog_freq_divider.sv
// Programmable clock divider with glitch-free divisor changes.
// New divisors are staged and applied only at a period boundary.
module prog_freq_divider #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_in,
    input  logic             load,
    output logic             clock_out,
    output logic             tick,
    output logic [WIDTH-1:0] div_active,
    output logic             pending
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] pdiv;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] load_val;
    logic             wrap;

    always_comb begin
        wrap     = (cnt == div_active - ONE);
        cnt_next = wrap ? '0 : cnt + ONE;
        // ceil(N/2) without an extra carry bit
        half     = (div_active >> 1) + {{(WIDTH-1){1'b0}}, div_active[0]};
        load_val = (div_in < TWO) ? TWO : div_in;
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            cnt        <= DEF_DIV - ONE;
            clock_out  <= 1'b0;
            tick       <= 1'b0;
            div_active <= DEF_DIV;
            pdiv       <= DEF_DIV;
            pending    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (enable) begin
                cnt       <= cnt_next;
                clock_out <= (cnt_next < half);
                tick      <= (cnt_next == '0);
                if (wrap && pending) begin
                    div_active <= pdiv;
                    pending    <= 1'b0;
                end
            end
            // a load on a wrap edge stays pending for the next boundary
            if (load) begin
                pdiv    <= load_val;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: doc/prog_freq_divider.md
PROG_FREQ_DIVIDER -- requirements
Module: prog_freq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the divisor and counter width in bits.
REQ-002 SHALL have parameter DEFAULT_DIV, default 4, giving the divisor in force after reset; legal range 2..2^WIDTH-1.
REQ-003 SHALL have port clock_in, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port enable, input, 1; high means the divider advances, low means all state holds.
REQ-006 SHALL have port div_in, input, WIDTH, the requested divisor N.
REQ-007 SHALL have port load, input, 1, a single-cycle request to capture div_in.
REQ-008 SHALL have port clock_out, output, 1, the registered divided clock.
REQ-009 SHALL have port tick, output, 1, a registered one-cycle pulse on each clock_out rising edge.
REQ-010 SHALL have port div_active, output, WIDTH, the divisor currently in force.
REQ-011 SHALL have port pending, output, 1, high while a captured divisor awaits application.

Function
REQ-012 SHALL hold an internal counter cnt (WIDTH bits), a pending divisor register pdiv and the flag pending.
REQ-013 On an enable edge, cnt_next SHALL be 0 when cnt == div_active-1 (wrap); otherwise cnt_next SHALL be cnt+1.
REQ-014 On an enable edge, clock_out SHALL be set to (cnt_next < H), where H = ceil(div_active/2), computed without overflow at WIDTH = max.
REQ-015 For divisor N, clock_out SHALL have period N cycles: high for ceil(N/2) cycles, low for floor(N/2) cycles, and no glitches.
REQ-016 On an enable edge where cnt_next == 0, tick SHALL be 1; on every other edge tick SHALL be 0.
REQ-017 When enable is low, cnt, clock_out and div_active SHALL hold their values and tick SHALL be 0.
REQ-018 When load is high on any edge, regardless of enable, pdiv SHALL capture div_in and pending SHALL go to 1.
REQ-019 A div_in value of 0 or 1 SHALL be clamped to 2 at capture.
REQ-020 If load is reasserted while pending is 1, the last captured value SHALL win.
REQ-021 On a wrap edge with pending == 1 (the value before that edge), div_active SHALL take pdiv and pending SHALL clear.
REQ-022 On a wrap edge, the clock_out compare SHALL use the old div_active, giving clock_out = 1 at cnt_next = 0; all later edges SHALL use the new value.
REQ-023 When load and a wrap edge coincide, the new value SHALL be captured and SHALL be applied at the next wrap, not at this one; pending SHALL remain 1.
REQ-024 A divisor change SHALL take effect only at a period boundary, so no partial or truncated high or low phase is ever produced.
REQ-025 Latency SHALL be as follows: the first enabled edge after reset SHALL drive clock_out and tick to 1.

Reset
REQ-026 While reset is high: cnt = DEFAULT_DIV-1, clock_out = 0, tick = 0, div_active = DEFAULT_DIV, pdiv = DEFAULT_DIV, pending = 0.
REQ-027 Reset SHALL act immediately, with no clock needed; asserting it mid-period or with pending = 1 SHALL discard the pending divisor.
REQ-028 After reset is deasserted, no output SHALL change before the first rising edge of clock_in with enable = 1.

Verification
REQ-029 Default run: reset, then enable = 1 with DEFAULT_DIV = 4 -> clock_out = 1,1,0,0 repeating from the first edge; tick high every 4th cycle aligned with each rise.
REQ-030 Odd divisor: load div_in = 5, then run 3 periods -> from the first wrap after load, clock_out is high 3 and low 2 each period; pending clears at that wrap; div_active = 5.
REQ-031 Clamp and boundary: load div_in = 0 -> div_active becomes 2 and clock_out toggles every cycle; load div_in = 16'hFFFF -> period is 65535 cycles (high 32768, low 32767).
REQ-032 Change mid-period: with N = 8 at cnt = 3, load 3, then load 6 at cnt = 5 -> the current 8-cycle period completes intact; the next period is 6; div_active never shows 3.
REQ-033 Coincident load and wrap: with N = 4, pulse load with div_in = 2 on the wrap edge -> the next period is still 4 with pending = 1; the following period is 2.
REQ-034 Enable and reset: drop enable for 7 cycles mid-high phase -> all outputs freeze, then resume with the exact remaining phase; assert reset asynchronously between edges with pending = 1 -> clock_out = 0 at once, div_active = 4, pending = 0.
